// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory with a 1-cycle read latency between the
// processor's fetch (imem) and load/store (dmem) ports. Each cycle at most one
// request is granted and forwarded to memory combinationally. The response
// goes back to its owner one cycle later. Data requests normally win a
// collision. A starvation counter makes sure a fetch held off for STARVE_MAX
// consecutive cycles wins the next arbitration.
//
// Parameters
//   STARVE_MAX : consecutive denied cycles tolerated for a valid fetch
//                (0 = fetch always wins)
//   CNT_W      : width of the starvation counter (must hold STARVE_MAX)
//
// Ports
//   clk_i                    clock, all state on posedge
//   rst_ni                   synchronous active-low reset
//   imemreq_val_i/_rdy_o     fetch request handshake, imemreq_addr_i
//   imemresp_val_o/_data_o   fetch response
//   dmemreq_val_i/_rdy_o     data request handshake
//   dmemreq_type_i           0 = read, 1 = write
//   dmemreq_addr_i/_wdata_i  data request payload
//   dmemresp_val_o/_rdata_o  data response (write ack carries rdata 0)
//   memreq_val_o/_type_o     request to backing memory
//   memreq_addr_o/_wdata_o   request payload to backing memory
//   memresp_rdata_i          memory read data, valid the cycle after a request
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        imemreq_val_i,
    output logic        imemreq_rdy_o,
    input  logic [31:0] imemreq_addr_i,
    output logic        imemresp_val_o,
    output logic [31:0] imemresp_data_o,

    input  logic        dmemreq_val_i,
    output logic        dmemreq_rdy_o,
    input  logic        dmemreq_type_i,
    input  logic [31:0] dmemreq_addr_i,
    input  logic [31:0] dmemreq_wdata_i,
    output logic        dmemresp_val_o,
    output logic [31:0] dmemresp_rdata_o,

    output logic        memreq_val_o,
    output logic        memreq_type_o,
    output logic [31:0] memreq_addr_o,
    output logic [31:0] memreq_wdata_o,
    input  logic [31:0] memresp_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DRD  = 2'd2,
        OWN_DWR  = 2'd3
    } owner_e;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    owner_e             owner_q;
    owner_e             owner_d;
    logic [CNT_W-1:0]   starve_cnt_q;
    logic [CNT_W-1:0]   starve_cnt_d;
    logic               grant_imem;
    logic               grant_dmem;

    // Grant selection: dmem wins unless imem has been held off long enough.
    // Nothing is granted while reset is asserted.
    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (rst_ni) begin
            grant_imem = imemreq_val_i &&
                         (!dmemreq_val_i || (starve_cnt_q == STARVE_LIM));
            grant_dmem = dmemreq_val_i && !grant_imem;
        end else begin
            grant_imem = 1'b0;
            grant_dmem = 1'b0;
        end
    end

    // Ready handshakes and forwarding of the granted request to memory.
    always_comb begin
        imemreq_rdy_o  = grant_imem;
        dmemreq_rdy_o  = grant_dmem;
        memreq_val_o   = grant_imem | grant_dmem;
        memreq_type_o  = 1'b0;
        memreq_addr_o  = 32'h0000_0000;
        memreq_wdata_o = 32'h0000_0000;
        if (grant_imem) begin
            // Fetches are always reads and never carry write data.
            memreq_addr_o = imemreq_addr_i;
        end else if (grant_dmem) begin
            memreq_type_o  = dmemreq_type_i;
            memreq_addr_o  = dmemreq_addr_i;
            memreq_wdata_o = dmemreq_wdata_i;
        end else begin
            memreq_addr_o = 32'h0000_0000;
        end
    end

    // Next owner of the response slot, decided by this cycle's grant.
    always_comb begin
        owner_d = OWN_NONE;
        if (grant_imem) begin
            owner_d = OWN_IMEM;
        end else if (grant_dmem) begin
            owner_d = dmemreq_type_i ? OWN_DWR : OWN_DRD;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Starvation counter: counts cycles a valid fetch loses to dmem.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_imem || !imemreq_val_i) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (grant_dmem) begin
            if (starve_cnt_q == STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // State registers with synchronous active-low reset; an in-flight
    // response is discarded by returning the owner to NONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Response steering: memory data goes only to the owning port.
    always_comb begin
        imemresp_val_o   = 1'b0;
        imemresp_data_o  = 32'h0000_0000;
        dmemresp_val_o   = 1'b0;
        dmemresp_rdata_o = 32'h0000_0000;
        if (rst_ni) begin
            case (owner_q)
                OWN_IMEM: begin
                    imemresp_val_o  = 1'b1;
                    imemresp_data_o = memresp_rdata_i;
                end
                OWN_DRD: begin
                    dmemresp_val_o   = 1'b1;
                    dmemresp_rdata_o = memresp_rdata_i;
                end
                OWN_DWR: begin
                    dmemresp_val_o = 1'b1;
                end
                default: begin
                    imemresp_val_o = 1'b0;
                    dmemresp_val_o = 1'b0;
                end
            endcase
        end else begin
            imemresp_val_o = 1'b0;
            dmemresp_val_o = 1'b0;
        end
    end

endmodule
